// File: rtl/bspi_cmd_sched_if.sv
// Requester and SPI-link signals of the command scheduler.
// slave: scheduler side. master: requesters plus link controller side.
interface bspi_cmd_sched_if #(
  parameter int NUM_REQ          = 4,
  parameter int SPI_MASTER_WIDTH = 64,
  parameter int SPI_SLAVE_WIDTH  = 96
);
  logic [NUM_REQ-1:0]                  req_vld_i;
  logic [NUM_REQ*SPI_MASTER_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]                  req_ack_o;
  logic [NUM_REQ-1:0]                  rsp_vld_o;
  logic [NUM_REQ-1:0]                  rsp_timeout_o;
  logic [SPI_SLAVE_WIDTH-1:0]          rsp_data_o;
  logic                                mspi_wr_en_o;
  logic [SPI_MASTER_WIDTH-1:0]         mspi_wr_data_o;
  logic                                sspi_rd_vld_i;
  logic [SPI_SLAVE_WIDTH-1:0]          sspi_rd_data_i;

  modport slave (
    input  req_vld_i, req_data_i, sspi_rd_vld_i, sspi_rd_data_i,
    output req_ack_o, rsp_vld_o, rsp_timeout_o, rsp_data_o, mspi_wr_en_o, mspi_wr_data_o
  );

  modport master (
    output req_vld_i, req_data_i, sspi_rd_vld_i, sspi_rd_data_i,
    input  req_ack_o, rsp_vld_o, rsp_timeout_o, rsp_data_o, mspi_wr_en_o, mspi_wr_data_o
  );
endinterface

// File: rtl/bspi_cmd_sched.sv
// Round-robin scheduler sharing one SPI link controller among NUM_REQ requesters.
// One transaction at a time: grant, issue command, wait for response or timeout,
// then an enforced idle gap. Unsolicited responses are dropped and counted.
module bspi_cmd_sched #(
  parameter real TCQ              = 0.1,
  parameter int  NUM_REQ          = 4,
  parameter int  SPI_MASTER_WIDTH = 64,
  parameter int  SPI_SLAVE_WIDTH  = 96,
  parameter int  RSP_TIMEOUT      = 2000,
  parameter int  GAP_CYCLES       = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sched_en_i,
  bspi_cmd_sched_if.slave        bus,
  output logic                   busy_o,
  output logic [15:0]            orphan_cnt_o
);
  localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAPW = $clog2(GAP_CYCLES + 1);
  localparam logic [15:0]     TO_LAST   = 16'(RSP_TIMEOUT - 1);
  localparam logic [GAPW-1:0] GAP_LAST  = GAPW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]   LAST_INIT = GW'(NUM_REQ - 1);

  // Reject unsupported configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || RSP_TIMEOUT < 2 || RSP_TIMEOUT > 65535 ||
      GAP_CYCLES < 1 || TCQ < 0.0) begin : g_bad_param
    $error("bspi_cmd_sched: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, GAP} state_t;

  state_t                      state, state_nxt;
  logic [GW-1:0]               last_grant;   // doubles as the active grant once latched
  logic [GW-1:0]               pick;
  logic                        pick_vld;
  logic [NUM_REQ-1:0]          rot;
  logic [NUM_REQ-1:0]          grant_oh;
  logic [15:0]                 to_cnt;
  logic [GAPW-1:0]             gap_cnt;
  logic [SPI_MASTER_WIDTH-1:0] cmd_q;
  logic [SPI_SLAVE_WIDTH-1:0]  rsp_data_q;
  logic [NUM_REQ-1:0]          rsp_vld_q, rsp_to_q;
  logic [15:0]                 orphan_q;
  logic                        start, rsp_hit, to_hit;

  // Round-robin search: rotate requests so bit 0 is last_grant+1, lowest set bit wins.
  always_comb begin
    rot  = NUM_REQ'({bus.req_vld_i, bus.req_vld_i} >> (int'(last_grant) + 1));
    pick = last_grant;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (rot[j]) pick = GW'((int'(last_grant) + 1 + j) % NUM_REQ);
  end

  assign pick_vld = |bus.req_vld_i;
  assign grant_oh = NUM_REQ'(1) << last_grant;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; a response always beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    rsp_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: if (sched_en_i && pick_vld) begin
        start     = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT_RSP;
      WAIT_RSP: begin
        if (bus.sspi_rd_vld_i) begin
          rsp_hit   = 1'b1;
          state_nxt = GAP;
        end else if (to_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, counters, response routing and orphan accounting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= LAST_INIT;
      cmd_q      <= '0;
      rsp_data_q <= '0;
      rsp_vld_q  <= '0;
      rsp_to_q   <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      orphan_q   <= '0;
    end else begin
      rsp_vld_q <= '0;
      rsp_to_q  <= '0;
      if (start) begin
        last_grant <= pick;
        cmd_q      <= bus.req_data_i[int'(pick)*SPI_MASTER_WIDTH +: SPI_MASTER_WIDTH];
      end
      if (state == ISSUE)         to_cnt <= '0;
      else if (state == WAIT_RSP) to_cnt <= to_cnt + 16'd1;
      if (state == GAP) gap_cnt <= gap_cnt + GAPW'(1);
      else              gap_cnt <= '0;
      if (rsp_hit) begin
        rsp_vld_q  <= grant_oh;
        rsp_data_q <= bus.sspi_rd_data_i;
      end
      if (to_hit) rsp_to_q <= grant_oh;
      if (bus.sspi_rd_vld_i && state != WAIT_RSP && orphan_q != 16'hFFFF)
        orphan_q <= orphan_q + 16'd1;
    end
  end

  assign bus.req_ack_o      = (state == ISSUE) ? grant_oh : '0;
  assign bus.mspi_wr_en_o   = (state == ISSUE);
  assign bus.mspi_wr_data_o = cmd_q;
  assign bus.rsp_vld_o      = rsp_vld_q;
  assign bus.rsp_timeout_o  = rsp_to_q;
  assign bus.rsp_data_o     = rsp_data_q;
  assign busy_o             = (state != IDLE);
  assign orphan_cnt_o       = orphan_q;
endmodule

// File: tb/tb_bspi_cmd_sched.sv
// Bench for bspi_cmd_sched: transaction-level reference (round-robin rule,
// cycle arithmetic for issue/response/timeout timing) against randomized traffic.
module tb_bspi_cmd_sched;
  localparam int NR = 4, MW = 64, SW = 96, RT = 64, GAP = 6;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic        busy;
  logic [15:0] orphan;
  int cyc = 0, n_chk = 0, n_err = 0;
  int m_last = NR - 1, m_orph = 0, m_idle = 0;
  logic [MW-1:0] m_wr  = '0;
  logic [SW-1:0] m_rsp = '0;

  bspi_cmd_sched_if #(.NUM_REQ(NR), .SPI_MASTER_WIDTH(MW), .SPI_SLAVE_WIDTH(SW)) bif ();

  bspi_cmd_sched #(.NUM_REQ(NR), .SPI_MASTER_WIDTH(MW), .SPI_SLAVE_WIDTH(SW),
                   .RSP_TIMEOUT(RT), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rst_i(rst), .sched_en_i(en), .bus(bif),
    .busy_o(busy), .orphan_cnt_o(orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: sim time limit reached, got cycle %0d required finish", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // First requester at or after last+1 (mod NR) with a pending request.
  function automatic int rr_pick(input int last, input logic [NR-1:0] m);
    for (int i = 1; i <= NR; i++)
      if (m[(last + i) % NR]) return (last + i) % NR;
    return -1;
  endfunction

  // One full transaction. dly>0: response in cycle ISSUE+dly; dly==0: no response.
  task automatic txn(input logic [NR-1:0] mask, input int dly, input bit fixed,
                     input logic [MW-1:0] fcmd, input logic [SW-1:0] frsp, output int g_obs);
    logic [MW-1:0] d [NR];
    logic [SW-1:0] word;
    int g, k, t_iss, exp_iss;
    logic early;
    g = rr_pick(m_last, mask);
    for (int i = 0; i < NR; i++) begin
      d[i] = {$urandom, $urandom};
      if (fixed && i == g) d[i] = fcmd;
      bif.req_data_i[i*MW +: MW] = d[i];
    end
    word = fixed ? frsp : {$urandom, $urandom, $urandom};
    bif.req_vld_i = mask;
    k = cyc;
    exp_iss = ((k > m_idle) ? k : m_idle) + 1;
    t_iss = -1;
    g_obs = -1;
    for (int n = 0; n < RT + GAP + 8 && t_iss < 0; n++) begin
      @(negedge clk);
      if (bif.mspi_wr_en_o) t_iss = cyc;
    end
    if (t_iss < 0) begin
      chk("issue_wait", 0, 1);
      bif.req_vld_i = '0;
      return;
    end
    for (int i = 0; i < NR; i++) if (bif.req_ack_o[i]) g_obs = i;
    chk("issue_cycle", t_iss, exp_iss);
    chk("ack_onehot", bif.req_ack_o, NR'(1) << g);
    chk("wr_data", bif.mspi_wr_data_o, d[g]);
    m_last = g;
    m_wr   = d[g];
    bif.req_vld_i[g] = 1'b0;
    @(negedge clk);
    chk("issue_one_cycle", {bif.req_ack_o, bif.mspi_wr_en_o, busy}, {NR'(0), 1'b0, 1'b1});
    chk("wr_data_hold", bif.mspi_wr_data_o, m_wr);
    early = 1'b0;
    if (dly > 0) begin
      while (cyc < t_iss + dly) begin
        early |= |{bif.rsp_vld_o, bif.rsp_timeout_o};
        @(negedge clk);
      end
      early |= |{bif.rsp_vld_o, bif.rsp_timeout_o};
      bif.sspi_rd_vld_i  = 1'b1;
      bif.sspi_rd_data_i = word;
      @(negedge clk);
      bif.sspi_rd_vld_i  = 1'b0;
      bif.sspi_rd_data_i = {$urandom, $urandom, $urandom};
      chk("rsp_vld", bif.rsp_vld_o, NR'(1) << g);
      chk("rsp_data", bif.rsp_data_o, word);
      chk("rsp_no_to", bif.rsp_timeout_o, 0);
      m_rsp = word;
    end else begin
      while (cyc < t_iss + RT + 1) begin
        early |= |{bif.rsp_vld_o, bif.rsp_timeout_o};
        @(negedge clk);
      end
      chk("timeout", bif.rsp_timeout_o, NR'(1) << g);
      chk("to_no_vld", bif.rsp_vld_o, 0);
    end
    chk("early_pulse", early, 0);
    m_idle = cyc + GAP;
    @(negedge clk);
    chk("pulse_end", {bif.rsp_vld_o, bif.rsp_timeout_o}, 0);
    chk("rsp_data_hold", bif.rsp_data_o, m_rsp);
    chk("busy_gap", busy, 1);
    bif.req_vld_i = '0;
  endtask

  initial begin
    int g, t, sel, dly;
    int fair_exp [5] = '{0, 1, 2, 3, 0};
    logic any;
    bif.req_vld_i      = '0;
    bif.req_data_i     = '0;
    bif.sspi_rd_vld_i  = 1'b0;
    bif.sspi_rd_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_pulses", {bif.req_ack_o, bif.rsp_vld_o, bif.rsp_timeout_o, bif.mspi_wr_en_o, busy}, 0);
    chk("rst_wr_data", bif.mspi_wr_data_o, 0);
    chk("rst_rsp_data", bif.rsp_data_o, 0);
    chk("rst_orphan", orphan, 0);
    rst = 1'b0;
    en  = 1'b1;
    m_idle = cyc;

    // Fairness: all requesters pending, each answered 50 cycles after issue.
    for (int i = 0; i < 5; i++) begin
      txn('1, 50, 1'b0, '0, '0, g);
      chk("fair_order", g, fair_exp[i]);
    end

    // Single request with known command and response.
    txn(4'b0100, 5, 1'b1, 64'hA5A5_0000_0000_0003, 96'h1234_5678_9ABC_DEF0_1122_3344, g);
    chk("single_grant", g, 2);

    // Timeout on requester 1, then requester 2 serviced normally.
    txn(4'b0010, 0, 1'b0, '0, '0, g);
    chk("to_grant", g, 1);
    txn(4'b0100, 20, 1'b0, '0, '0, g);
    chk("after_to_grant", g, 2);

    // Response on the final counter cycle: response only.
    txn(4'b1000, RT, 1'b0, '0, '0, g);

    // Orphans while idle.
    while (cyc < m_idle) @(negedge clk);
    chk("idle_busy", busy, 0);
    any = 1'b0;
    repeat (3) begin
      bif.sspi_rd_vld_i  = 1'b1;
      bif.sspi_rd_data_i = {$urandom, $urandom, $urandom};
      @(negedge clk);
      bif.sspi_rd_vld_i = 1'b0;
      any |= |bif.rsp_vld_o;
      @(negedge clk);
      any |= |bif.rsp_vld_o;
    end
    m_orph += 3;
    chk("orph_3", orphan, m_orph);
    chk("orph_no_rsp", any, 0);
    chk("orph_data_hold", bif.rsp_data_o, m_rsp);

    // Randomized traffic, occasional orphan during the gap.
    for (int r = 0; r < 25; r++) begin
      sel = $urandom_range(0, 9);
      dly = (sel == 0) ? 0 : (sel == 1) ? RT : $urandom_range(1, RT - 1);
      txn(NR'($urandom_range(1, 15)), dly, 1'b0, '0, '0, g);
      if ($urandom_range(0, 3) == 0) begin
        bif.sspi_rd_vld_i  = 1'b1;
        bif.sspi_rd_data_i = {$urandom, $urandom, $urandom};
        @(negedge clk);
        bif.sspi_rd_vld_i = 1'b0;
        m_orph++;
        chk("gap_orph_cnt", orphan, m_orph);
        chk("gap_orph_rsp", {bif.rsp_vld_o, bif.rsp_data_o}, {NR'(0), m_rsp});
      end
    end

    // Reset in WAIT_RSP, then hold off grants with sched_en low.
    while (cyc < m_idle) @(negedge clk);
    bif.req_vld_i = 4'b0100;
    t = -1;
    for (int n = 0; n < 8 && t < 0; n++) begin
      @(negedge clk);
      if (bif.mspi_wr_en_o) t = cyc;
    end
    chk("rst_pre_issue", t >= 0, 1);
    bif.req_vld_i = '0;
    repeat (10) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    rst = 1'b1;
    en  = 1'b0;
    bif.req_vld_i = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_pulses", {bif.req_ack_o, bif.rsp_vld_o, bif.rsp_timeout_o, bif.mspi_wr_en_o, busy}, 0);
    chk("mid_rst_data", {bif.mspi_wr_data_o, bif.rsp_data_o, orphan}, 0);
    m_last = NR - 1; m_orph = 0; m_wr = '0; m_rsp = '0;
    any = 1'b0;
    repeat (2 * RT) begin
      @(negedge clk);
      any |= |{bif.req_ack_o, bif.rsp_vld_o, bif.rsp_timeout_o, bif.mspi_wr_en_o, busy};
    end
    chk("en_low_quiet", any, 0);
    en = 1'b1;
    @(negedge clk);
    chk("en_grant", {bif.mspi_wr_en_o, bif.req_ack_o}, {1'b1, 4'b0001});
    bif.req_vld_i = '0;
    repeat (RT + GAP + 4) @(negedge clk);
    chk("en_done_idle", busy, 0);
    chk("en_done_data", bif.rsp_data_o, m_rsp);

    // Orphan counter saturation.
    bif.sspi_rd_vld_i = 1'b1;
    any = 1'b0;
    repeat (65534) begin
      @(negedge clk);
      any |= |bif.rsp_vld_o;
    end
    chk("orph_fffe", orphan, 16'hFFFE);
    @(negedge clk);
    chk("orph_ffff", orphan, 16'hFFFF);
    repeat (5) begin
      @(negedge clk);
      any |= |bif.rsp_vld_o;
    end
    bif.sspi_rd_vld_i = 1'b0;
    chk("orph_sat", orphan, 16'hFFFF);
    chk("orph_sat_no_rsp", any, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
